// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID register, req/gnt/rvalid fetch port and delay-slot redirect.
// Optional IF_ALIGN_CHECK_EN adds misaligned-fetch exception reporting (adel_o/badvaddr_o).
module if_fetch_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic              adel_o,
  output logic [ADDR_W-1:0] badvaddr_o
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              redirect_pend_q, redirect_pend_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0] skid_inst_q, skid_inst_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              ld;
  logic [ADDR_W-1:0] ld_pc;
  logic [DATA_W-1:0] ld_inst;
  logic [ADDR_W-1:0] req_addr;
  logic              misaligned;
  logic              parked;

`ifdef IF_ALIGN_CHECK_EN
  logic              parked_q, parked_d;
  logic              adel_q, adel_d;
  logic [ADDR_W-1:0] badvaddr_q, badvaddr_d;
  logic              ld_exc;

  assign req_addr   = fetch_pc_q;
  assign misaligned = (fetch_pc_q[1:0] != 2'b00);
  assign parked     = parked_q;
  assign adel_o     = adel_q;
  assign badvaddr_o = badvaddr_q;
`else
  assign req_addr   = fetch_pc_q & ~ADDR_W'(3);
  assign misaligned = 1'b0;
  assign parked     = 1'b0;
`endif

  assign imem_req_o   = (state_q == REQ) && !misaligned;
  assign imem_addr_o  = req_addr;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    fetch_addr_d    = fetch_addr_q;
    tgt_d           = tgt_q;
    redirect_pend_d = redirect_pend_q;
    skid_pc_d       = skid_pc_q;
    skid_inst_d     = skid_inst_q;
    pc_d            = pc_q;
    inst_d          = inst_q;
    valid_d         = valid_q;
    ld              = 1'b0;
    ld_pc           = '0;
    ld_inst         = '0;
`ifdef IF_ALIGN_CHECK_EN
    parked_d        = parked_q;
    adel_d          = adel_q;
    badvaddr_d      = badvaddr_q;
    ld_exc          = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
`ifdef IF_ALIGN_CHECK_EN
        // A parked fetch only resumes at a fresh branch target.
        if (parked_q) begin
          if (branch_flag_i) begin
            state_d         = REQ;
            parked_d        = 1'b0;
            fetch_pc_d      = branch_target_address_i;
            redirect_pend_d = 1'b0;
          end
        end else begin
          state_d = REQ;
        end
`else
        state_d = REQ;
`endif
      end
      REQ: begin
        if (misaligned) begin
`ifdef IF_ALIGN_CHECK_EN
          if (!stall_i || !valid_q) begin
            ld       = 1'b1;
            ld_pc    = fetch_pc_q;
            ld_exc   = 1'b1;
            state_d  = IDLE;
            parked_d = 1'b1;
          end
`endif
        end else if (imem_gnt_i) begin
          fetch_addr_d    = req_addr;
          redirect_pend_d = 1'b0;
          state_d         = WAIT;
          if (branch_flag_i) begin
            fetch_pc_d = branch_target_address_i;
          end else if (redirect_pend_q) begin
            fetch_pc_d = tgt_q;
          end else begin
            fetch_pc_d = req_addr + ADDR_W'(4);
          end
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (stall_i && valid_q) begin
            skid_pc_d   = fetch_addr_q;
            skid_inst_d = imem_rdata_i;
            state_d     = HOLD;
          end else begin
            ld      = 1'b1;
            ld_pc   = fetch_addr_q;
            ld_inst = imem_rdata_i;
            state_d = REQ;
          end
        end
      end
      HOLD: begin
        if (!stall_i) begin
          ld      = 1'b1;
          ld_pc   = skid_pc_q;
          ld_inst = skid_inst_q;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Once the delay slot has been granted, a redirect retargets the next fetch directly.
    if (branch_flag_i && !parked) begin
      if ((state_q == WAIT) || (state_q == HOLD)) begin
        fetch_pc_d = branch_target_address_i;
      end else if (!((state_q == REQ) && imem_gnt_i && !misaligned)) begin
        redirect_pend_d = 1'b1;
        tgt_d           = branch_target_address_i;
      end
    end

    if (ld) begin
      pc_d    = ld_pc;
      inst_d  = ld_inst;
      valid_d = 1'b1;
`ifdef IF_ALIGN_CHECK_EN
      adel_d  = ld_exc;
      if (ld_exc) badvaddr_d = ld_pc;
`endif
    end else if (!stall_i) begin
      pc_d    = '0;
      inst_d  = '0;
      valid_d = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      adel_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      fetch_pc_q      <= RESET_PC;
      fetch_addr_q    <= '0;
      tgt_q           <= '0;
      redirect_pend_q <= 1'b0;
      skid_pc_q       <= '0;
      skid_inst_q     <= '0;
      pc_q            <= '0;
      inst_q          <= '0;
      valid_q         <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      parked_q        <= 1'b0;
      adel_q          <= 1'b0;
      badvaddr_q      <= '0;
`endif
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      fetch_addr_q    <= fetch_addr_d;
      tgt_q           <= tgt_d;
      redirect_pend_q <= redirect_pend_d;
      skid_pc_q       <= skid_pc_d;
      skid_inst_q     <= skid_inst_d;
      pc_q            <= pc_d;
      inst_q          <= inst_d;
      valid_q         <= valid_d;
`ifdef IF_ALIGN_CHECK_EN
      parked_q        <= parked_d;
      adel_q          <= adel_d;
      badvaddr_q      <= badvaddr_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage: a behavioural memory plus a transaction-level reference model.
// Build with IF_ALIGN_CHECK_EN defined to also exercise the misaligned-fetch exception.
module tb_if_fetch_stage;
  localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef IF_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch, gnt, rvalid;
  logic [31:0] btgt, rdata;
  logic        imem_req_o;
  logic [31:0] imem_addr_o, pc_o, inst_o;
  logic        inst_valid_o;
`ifdef IF_ALIGN_CHECK_EN
  logic        adel_o;
  logic [31:0] badvaddr_o;
`endif

  if_fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(branch),
    .branch_target_address_i(btgt), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o)
`ifdef IF_ALIGN_CHECK_EN
    , .adel_o(adel_o), .badvaddr_o(badvaddr_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: fetch stream, in-flight queue, skid slot and IF/ID contents.
  bit          mIdle, mReqPending, mArmed, mSkidFull, mValid, mAdel, mParked;
  logic [31:0] mNext, mTgt, mSkidPc, mSkidInst, mPc, mInst, mBad;
  logic [31:0] mInflight[$];

  // Memory side of the handshake.
  bit          memBusy;
  logic [31:0] memAddr;
  int          gntWait, rvLat, gntMax, rvMax;

  function automatic logic [31:0] dataOf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0001;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mIdle = 1'b1; mReqPending = 1'b0; mArmed = 1'b0; mSkidFull = 1'b0;
    mValid = 1'b0; mAdel = 1'b0; mParked = 1'b0;
    mNext = RPC; mTgt = '0; mPc = '0; mInst = '0; mBad = '0;
    mInflight.delete();
  endtask

  task automatic modelStep();
    bit pendNow, ldNow, excNow;
    logic [31:0] a, ldPc, ldInst;
    if (rst) begin
      modelReset();
      return;
    end
    pendNow = mReqPending;
    ldNow = 1'b0; excNow = 1'b0; ldPc = '0; ldInst = '0;
    if (branch) begin
      if (mParked) begin
        mNext = btgt; mParked = 1'b0; mReqPending = 1'b1; mArmed = 1'b0;
      end else if (mIdle || pendNow) begin
        mArmed = 1'b1; mTgt = btgt;
      end else begin
        mNext = btgt;
      end
    end
    if (mIdle) begin
      mIdle = 1'b0;
      mReqPending = 1'b1;
    end else if (pendNow) begin
      if (ALIGN_EN && (mNext[1:0] != 2'b00)) begin
        if (!stall || !mValid) begin
          ldNow = 1'b1; excNow = 1'b1; ldPc = mNext;
          mReqPending = 1'b0; mParked = 1'b1;
        end
      end else if (gnt) begin
        a = mNext & ~32'h3;
        mInflight.push_back(a);
        mNext = mArmed ? mTgt : a + 32'd4;
        mArmed = 1'b0;
        mReqPending = 1'b0;
      end
    end else if (rvalid && (mInflight.size() > 0)) begin
      a = mInflight.pop_front();
      if (stall && mValid) begin
        mSkidFull = 1'b1; mSkidPc = a; mSkidInst = dataOf(a);
      end else begin
        ldNow = 1'b1; ldPc = a; ldInst = dataOf(a); mReqPending = 1'b1;
      end
    end else if (mSkidFull && !stall) begin
      ldNow = 1'b1; ldPc = mSkidPc; ldInst = mSkidInst;
      mSkidFull = 1'b0; mReqPending = 1'b1;
    end
    if (ldNow) begin
      mValid = 1'b1; mPc = ldPc; mInst = ldInst; mAdel = excNow;
      if (excNow) mBad = ldPc;
    end else if (!stall) begin
      mValid = 1'b0; mPc = '0; mInst = '0; mAdel = 1'b0;
    end
  endtask

  // One cycle: check outputs at the falling edge, drive inputs, advance model at the rising edge.
  task automatic applyStimulus(input bit st, input bit br, input logic [31:0] bt, input bit r);
    bit expReq;
    expReq = mReqPending && !(ALIGN_EN && (mNext[1:0] != 2'b00));
    checkOutput("pc_o", pc_o, mPc);
    checkOutput("inst_o", inst_o, mInst);
    checkOutput("inst_valid_o", 32'(inst_valid_o), 32'(mValid));
    checkOutput("imem_req_o", 32'(imem_req_o), 32'(expReq));
    if (expReq) checkOutput("imem_addr_o", imem_addr_o, mNext & ~32'h3);
`ifdef IF_ALIGN_CHECK_EN
    checkOutput("adel_o", 32'(adel_o), 32'(mAdel));
    checkOutput("badvaddr_o", badvaddr_o, mBad);
`endif
    rst = r; stall = st; branch = br; btgt = bt;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    if (memBusy) begin
      if (rvLat == 0) begin
        rvalid = 1'b1;
        rdata = dataOf(memAddr);
      end else begin
        rvLat--;
      end
    end else if (imem_req_o) begin
      if (gntWait == 0) begin
        gnt = 1'b1;
        memAddr = imem_addr_o;
      end else begin
        gntWait--;
      end
    end
    @(posedge clk);
    modelStep();
    if (gnt) begin
      memBusy = 1'b1;
      rvLat = $urandom_range(0, rvMax);
      gntWait = $urandom_range(0, gntMax);
    end
    if (rvalid) memBusy = 1'b0;
    @(negedge clk);
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic waitBusy(input int maxCyc);
    bit found;
    found = memBusy;
    for (int i = 0; i < maxCyc && !found; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      found = memBusy;
    end
    checkOutput("wait_busy", 32'(found), 32'd1);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch = 1'b0; btgt = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    memBusy = 1'b0; memAddr = '0; gntWait = 0; rvLat = 0; gntMax = 0; rvMax = 0;
    modelReset();
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("reset_req", 32'(imem_req_o), 32'd0);
    checkOutput("reset_addr", imem_addr_o, RPC);
    checkOutput("reset_valid", 32'(inst_valid_o), 32'd0);

    $display("[TB] zero-wait sequential fetch");
    runIdle(12);

    $display("[TB] delayed grant");
    waitBusy(20);
    gntWait = 3;
    runIdle(10);

    $display("[TB] stall with skid");
    waitBusy(20);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkOutput("hold_no_req", 32'(imem_req_o), 32'd0);
    runIdle(6);

    $display("[TB] branch with outstanding delay slot");
    waitBusy(20);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0);
    runIdle(8);

    $display("[TB] branch held under stall");
    waitBusy(20);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 32'h200, 1'b0);
    runIdle(10);

    $display("[TB] reset during outstanding fetch");
    waitBusy(20);
    rvLat = 1;
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("rst_mid_valid", 32'(inst_valid_o), 32'd0);
    checkOutput("rst_mid_addr", imem_addr_o, RPC);
    runIdle(8);

`ifdef IF_ALIGN_CHECK_EN
    $display("[TB] misaligned branch target");
    waitBusy(20);
    applyStimulus(1'b0, 1'b1, 32'h102, 1'b0);
    runIdle(6);
    checkOutput("park_no_req", 32'(imem_req_o), 32'd0);
    checkOutput("park_model", 32'(mParked), 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b0);
    runIdle(8);
`endif

    $display("[TB] randomized traffic");
    gntMax = 2; rvMax = 3;
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4,
                    32'($urandom_range(0, 255)) << 2, 1'b0);
    end
    gntMax = 0; rvMax = 0;
    runIdle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
